// File: rtl/vip_color_pkg.sv
// Colour-space conversion constants shared by the VIP RGB->YCbCr converter:
// matrix select enum, x256 coefficient table, rounding constant and offsets.
package vip_color_pkg;

  typedef enum logic [1:0] {
    MODE_601_FULL   = 2'd0,
    MODE_601_STUDIO = 2'd1,
    MODE_709_FULL   = 2'd2,
    MODE_RESERVED   = 2'd3
  } color_mode_e;

  localparam int COEF_W      = 9;
  localparam int FRAC_W      = 8;
  localparam int ROUND_CONST = 128;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Row 0 = Y, 1 = Cb, 2 = Cr; column 0 = R, 1 = G, 2 = B.
  typedef coef_t [0:2][0:2] coef_mat_t;

  localparam coef_mat_t COEF_TABLE [3] = '{
    '{'{ 9'sd77,   9'sd150,  9'sd29 },
      '{-9'sd43,  -9'sd85,   9'sd128},
      '{ 9'sd128, -9'sd107, -9'sd21 }},
    '{'{ 9'sd66,   9'sd129,  9'sd25 },
      '{-9'sd38,  -9'sd74,   9'sd112},
      '{ 9'sd112, -9'sd94,  -9'sd18 }},
    '{'{ 9'sd54,   9'sd183,  9'sd19 },
      '{-9'sd29,  -9'sd99,   9'sd128},
      '{ 9'sd128, -9'sd116, -9'sd12 }}
  };

  // Raw config code to matrix; the unused code falls back to 601 full range.
  function automatic color_mode_e mode_decode(input logic [1:0] raw);
    case (raw)
      2'd1:    mode_decode = MODE_601_STUDIO;
      2'd2:    mode_decode = MODE_709_FULL;
      default: mode_decode = MODE_601_FULL;
    endcase
  endfunction

  function automatic coef_mat_t coef_lookup(input color_mode_e mode);
    case (mode)
      MODE_601_STUDIO: coef_lookup = COEF_TABLE[1];
      MODE_709_FULL:   coef_lookup = COEF_TABLE[2];
      default:         coef_lookup = COEF_TABLE[0];
    endcase
  endfunction

  // Chroma midpoint H = 2^(DATA_W-1).
  function automatic int c_offset(input int data_w);
    c_offset = 32'sd1 <<< (data_w - 32'sd1);
  endfunction

  // Studio-range luma sits at H/8 (16 for 8-bit); full-range luma has no offset.
  function automatic int y_offset(input int data_w, input color_mode_e mode);
    case (mode)
      MODE_601_STUDIO: y_offset = c_offset(data_w) / 32'sd8;
      default:         y_offset = 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/vip_chroma_422_decim.sv
// Stage 4 of the converter: 4:2:2 chroma averaging/interleave, or a plain
// pass-through register in 4:4:4. Outputs are zero whenever href is low.
module vip_chroma_422_decim
  import vip_color_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_422,
  input  logic              href,
  input  logic              clken,
  input  logic [DATA_W-1:0] y3,
  input  logic [DATA_W-1:0] cb3,
  input  logic [DATA_W-1:0] cr3,
  output logic [DATA_W-1:0] y4,
  output logic [DATA_W-1:0] c4,
  output logic [DATA_W-1:0] cr4,
  output logic              sel4
);

  logic              valid_s;
  logic              parity_r;
  logic              first_r;
  logic [DATA_W-1:0] prev_cb_r;
  logic [DATA_W-1:0] prev_cr_r;
  logic [DATA_W-1:0] ref_cb_s;
  logic [DATA_W-1:0] ref_cr_s;
  logic [DATA_W-1:0] avg_cb_s;
  logic [DATA_W-1:0] avg_cr_s;
  logic [DATA_W-1:0] y_nxt_s;
  logic [DATA_W-1:0] c_nxt_s;
  logic [DATA_W-1:0] cr_nxt_s;
  logic              sel_nxt_s;
  logic [DATA_W-1:0] y4_r;
  logic [DATA_W-1:0] c4_r;
  logic [DATA_W-1:0] cr4_r;
  logic              sel4_r;

  assign valid_s = href & clken;

  // Round-half-up mean of two components, computed one bit wider.
  function automatic logic [DATA_W-1:0] avg_round(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, 1'b1};
    avg_round = s[DATA_W:1];
  endfunction

  // Neighbour selection: the first pixel of a line averages with itself.
  always_comb begin
    ref_cb_s = prev_cb_r;
    ref_cr_s = prev_cr_r;
    if (first_r) begin
      ref_cb_s = cb3;
      ref_cr_s = cr3;
    end else begin
      ref_cb_s = prev_cb_r;
      ref_cr_s = prev_cr_r;
    end
    avg_cb_s = avg_round(cb3, ref_cb_s);
    avg_cr_s = avg_round(cr3, ref_cr_s);
  end

  // Output mux: blanked outside href, interleaved chroma in 4:2:2.
  always_comb begin
    y_nxt_s   = {DATA_W{1'b0}};
    c_nxt_s   = {DATA_W{1'b0}};
    cr_nxt_s  = {DATA_W{1'b0}};
    sel_nxt_s = 1'b0;
    if (!href) begin
      sel_nxt_s = 1'b0;
    end else if (en_422) begin
      y_nxt_s   = y3;
      c_nxt_s   = parity_r ? avg_cr_s : avg_cb_s;
      sel_nxt_s = parity_r;
    end else begin
      y_nxt_s  = y3;
      c_nxt_s  = cb3;
      cr_nxt_s = cr3;
    end
  end

  // Line parity, line-start flag and previous-chroma registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_r  <= 1'b0;
      first_r   <= 1'b0;
      prev_cb_r <= {DATA_W{1'b0}};
      prev_cr_r <= {DATA_W{1'b0}};
    end else if (!href) begin
      parity_r <= 1'b0;
      first_r  <= 1'b1;
    end else if (valid_s) begin
      parity_r  <= ~parity_r;
      first_r   <= 1'b0;
      prev_cb_r <= cb3;
      prev_cr_r <= cr3;
    end else begin
      parity_r <= parity_r;
    end
  end

  // Stage-4 output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y4_r   <= {DATA_W{1'b0}};
      c4_r   <= {DATA_W{1'b0}};
      cr4_r  <= {DATA_W{1'b0}};
      sel4_r <= 1'b0;
    end else begin
      y4_r   <= y_nxt_s;
      c4_r   <= c_nxt_s;
      cr4_r  <= cr_nxt_s;
      sel4_r <= sel_nxt_s;
    end
  end

  assign y4   = y4_r;
  assign c4   = c4_r;
  assign cr4  = cr4_r;
  assign sel4 = sel4_r;

endmodule

// File: rtl/vip_rgb_ycbcr_conv.sv
// RGB -> YCbCr converter, fixed 4-clock pipeline: products, sums, shift/offset/
// saturate, then 4:2:2 decimation. Matrix and 4:2:2 select are frame-latched
// on the vsync rising edge and travel down the pipe with each pixel.
module vip_rgb_ycbcr_conv
  import vip_color_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_422,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_red,
  input  logic [DATA_W-1:0] per_img_green,
  input  logic [DATA_W-1:0] per_img_blue,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_Y,
  output logic [DATA_W-1:0] post_img_Cb,
  output logic [DATA_W-1:0] post_img_Cr,
  output logic              post_chroma_sel
);

  localparam int ACC_W = DATA_W + 11;
  localparam logic signed [ACC_W-1:0] RND_S     = ACC_W'(ROUND_CONST);
  localparam logic signed [ACC_W-1:0] MAX_S     = ACC_W'((32'sd1 <<< DATA_W) - 32'sd1);
  localparam logic signed [ACC_W-1:0] C_OFF_S   = ACC_W'(c_offset(DATA_W));
  localparam logic signed [ACC_W-1:0] Y_OFF_ST_S = ACC_W'(y_offset(DATA_W, MODE_601_STUDIO));
  localparam logic signed [ACC_W-1:0] Y_OFF_FR_S = ACC_W'(y_offset(DATA_W, MODE_601_FULL));

  // Frame configuration
  logic        vsync_d_r;
  logic        vsync_rise_s;
  color_mode_e frame_mode_r;
  logic        frame_422_r;

  // Pipeline
  coef_mat_t                coef_mat_s;
  logic signed [ACC_W-1:0]  prod_s  [9];
  logic signed [ACC_W-1:0]  prod1_r [9];
  logic signed [ACC_W-1:0]  sum_s   [3];
  logic signed [ACC_W-1:0]  sum2_r  [3];
  logic signed [ACC_W-1:0]  y_off_s;
  logic [DATA_W-1:0]        y3_s, cb3_s, cr3_s;
  logic [DATA_W-1:0]        y3_r, cb3_r, cr3_r;
  color_mode_e              mode1_r, mode2_r;
  logic                     f422_1_r, f422_2_r, f422_3_r;
  logic [2:0]               sync1_r, sync2_r, sync3_r, sync4_r;

  // Unsigned component times signed coefficient, both extended to ACC_W.
  function automatic logic signed [ACC_W-1:0] mul_term(input logic [DATA_W-1:0] comp,
                                                       input logic [COEF_W-1:0] coef);
    logic signed [ACC_W-1:0] comp_ext;
    logic signed [ACC_W-1:0] coef_ext;
    comp_ext = $signed({{(ACC_W-DATA_W){1'b0}}, comp});
    coef_ext = $signed({{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef});
    mul_term = comp_ext * coef_ext;
  endfunction

  // Clamp a signed result into the unsigned component range.
  function automatic logic [DATA_W-1:0] sat_comp(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1]) begin
      sat_comp = {DATA_W{1'b0}};
    end else if (v > MAX_S) begin
      sat_comp = {DATA_W{1'b1}};
    end else begin
      sat_comp = v[DATA_W-1:0];
    end
  endfunction

  assign vsync_rise_s = per_frame_vsync & ~vsync_d_r;

  // Latch matrix and chroma format once per frame on the vsync rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d_r    <= 1'b0;
      frame_mode_r <= MODE_601_FULL;
      frame_422_r  <= 1'b0;
    end else begin
      vsync_d_r <= per_frame_vsync;
      if (vsync_rise_s) begin
        frame_mode_r <= mode_decode(cfg_mode);
        frame_422_r  <= cfg_422;
      end else begin
        frame_mode_r <= frame_mode_r;
        frame_422_r  <= frame_422_r;
      end
    end
  end

  // Stage-1 combinational products, row-major (Y, Cb, Cr) x (R, G, B).
  always_comb begin
    coef_mat_s = coef_lookup(frame_mode_r);
    prod_s[0]  = mul_term(per_img_red,   coef_mat_s[0][0]);
    prod_s[1]  = mul_term(per_img_green, coef_mat_s[0][1]);
    prod_s[2]  = mul_term(per_img_blue,  coef_mat_s[0][2]);
    prod_s[3]  = mul_term(per_img_red,   coef_mat_s[1][0]);
    prod_s[4]  = mul_term(per_img_green, coef_mat_s[1][1]);
    prod_s[5]  = mul_term(per_img_blue,  coef_mat_s[1][2]);
    prod_s[6]  = mul_term(per_img_red,   coef_mat_s[2][0]);
    prod_s[7]  = mul_term(per_img_green, coef_mat_s[2][1]);
    prod_s[8]  = mul_term(per_img_blue,  coef_mat_s[2][2]);
  end

  // Stage 1: register products with the frame config and sync bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod1_r  <= '{default: '0};
      mode1_r  <= MODE_601_FULL;
      f422_1_r <= 1'b0;
      sync1_r  <= 3'b000;
    end else begin
      prod1_r  <= prod_s;
      mode1_r  <= frame_mode_r;
      f422_1_r <= frame_422_r;
      sync1_r  <= {per_frame_vsync, per_frame_href, per_frame_clken};
    end
  end

  // Stage-2 combinational sums with the rounding constant folded in.
  always_comb begin
    sum_s[0] = prod1_r[0] + prod1_r[1] + prod1_r[2] + RND_S;
    sum_s[1] = prod1_r[3] + prod1_r[4] + prod1_r[5] + RND_S;
    sum_s[2] = prod1_r[6] + prod1_r[7] + prod1_r[8] + RND_S;
  end

  // Stage 2: register sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum2_r   <= '{default: '0};
      mode2_r  <= MODE_601_FULL;
      f422_2_r <= 1'b0;
      sync2_r  <= 3'b000;
    end else begin
      sum2_r   <= sum_s;
      mode2_r  <= mode1_r;
      f422_2_r <= f422_1_r;
      sync2_r  <= sync1_r;
    end
  end

  // Stage-3 combinational floor shift, offset and saturation.
  always_comb begin
    if (mode2_r == MODE_601_STUDIO) begin
      y_off_s = Y_OFF_ST_S;
    end else begin
      y_off_s = Y_OFF_FR_S;
    end
    y3_s  = sat_comp((sum2_r[0] >>> FRAC_W) + y_off_s);
    cb3_s = sat_comp((sum2_r[1] >>> FRAC_W) + C_OFF_S);
    cr3_s = sat_comp((sum2_r[2] >>> FRAC_W) + C_OFF_S);
  end

  // Stage 3: register saturated components.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y3_r     <= {DATA_W{1'b0}};
      cb3_r    <= {DATA_W{1'b0}};
      cr3_r    <= {DATA_W{1'b0}};
      f422_3_r <= 1'b0;
      sync3_r  <= 3'b000;
    end else begin
      y3_r     <= y3_s;
      cb3_r    <= cb3_s;
      cr3_r    <= cr3_s;
      f422_3_r <= f422_2_r;
      sync3_r  <= sync2_r;
    end
  end

  // Stage 4: sync bits aligned with the decimator output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync4_r <= 3'b000;
    end else begin
      sync4_r <= sync3_r;
    end
  end

  vip_chroma_422_decim #(
    .DATA_W(DATA_W)
  ) u_decim (
    .clk   (clk),
    .rst   (rst),
    .en_422(f422_3_r),
    .href  (sync3_r[1]),
    .clken (sync3_r[0]),
    .y3    (y3_r),
    .cb3   (cb3_r),
    .cr3   (cr3_r),
    .y4    (post_img_Y),
    .c4    (post_img_Cb),
    .cr4   (post_img_Cr),
    .sel4  (post_chroma_sel)
  );

  assign post_frame_vsync = sync4_r[2];
  assign post_frame_href  = sync4_r[1];
  assign post_frame_clken = sync4_r[0];

endmodule

// File: tb/tb_vip_rgb_ycbcr_conv.sv
// Scoreboard bench for vip_rgb_ycbcr_conv at DATA_W=8: stimulus pushes hand-
// computed expectations, a negedge monitor pops and compares each valid output.
module tb_vip_rgb_ycbcr_conv;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        cfg_mode = 2'd0;
  logic              cfg_422 = 1'b0;
  logic              per_frame_vsync = 1'b0;
  logic              per_frame_href = 1'b0;
  logic              per_frame_clken = 1'b0;
  logic [DATA_W-1:0] per_img_red = 8'd0;
  logic [DATA_W-1:0] per_img_green = 8'd0;
  logic [DATA_W-1:0] per_img_blue = 8'd0;
  logic              post_frame_vsync, post_frame_href, post_frame_clken;
  logic [DATA_W-1:0] post_img_Y, post_img_Cb, post_img_Cr;
  logic              post_chroma_sel;

  vip_rgb_ycbcr_conv #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_422(cfg_422),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_red(per_img_red),
    .per_img_green(per_img_green), .per_img_blue(per_img_blue),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_Y(post_img_Y),
    .post_img_Cb(post_img_Cb), .post_img_Cr(post_img_Cr),
    .post_chroma_sel(post_chroma_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       sel;
  } exp_t;

  exp_t sb_q[$];
  int   vs_q[$];
  exp_t mon_e;
  logic pv_prev = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every valid output pixel and vsync edge against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pv_prev = 1'b0;
      end else begin
        if (post_frame_href && post_frame_clken) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pixel actual=output_present expected=none_queued at t=%0t", $time);
          end else begin
            mon_e = sb_q.pop_front();
            check("latency", cyc, mon_e.due);
            check("Y", post_img_Y, mon_e.y);
            check("Cb", post_img_Cb, mon_e.cb);
            check("Cr", post_img_Cr, mon_e.cr);
            check("sel", post_chroma_sel, mon_e.sel);
          end
        end
        if (!post_frame_href)
          check("blank_zero", {post_img_Y, post_img_Cb, post_img_Cr, post_chroma_sel}, 32'd0);
        if (post_frame_vsync && !pv_prev) begin
          if (vs_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_vsync actual=rise expected=none_queued at t=%0t", $time);
          end else begin
            check("vsync_delay", cyc, vs_q.pop_front());
          end
        end
        pv_prev = post_frame_vsync;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      per_frame_vsync = 1'b0;
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
    end
  endtask

  task automatic vsync_pulse(input logic [1:0] mode, input logic f422);
    @(posedge clk); #1;
    cfg_mode = mode;
    cfg_422 = f422;
    per_frame_vsync = 1'b1;
    per_frame_href = 1'b0;
    per_frame_clken = 1'b0;
    vs_q.push_back(cyc + 4);
    @(posedge clk); #1;
    per_frame_vsync = 1'b1;
    idle(2);
  endtask

  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [7:0] ey, input logic [7:0] ecb, input logic [7:0] ecr,
                     input logic esel);
    @(posedge clk); #1;
    per_frame_href = 1'b1;
    per_frame_clken = 1'b1;
    per_img_red = r;
    per_img_green = g;
    per_img_blue = b;
    sb_q.push_back('{due: cyc + 4, y: ey, cb: ecb, cr: ecr, sel: esel});
  endtask

  task automatic gap();
    @(posedge clk); #1;
    per_frame_href = 1'b1;
    per_frame_clken = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_Y"}, post_img_Y, 32'd0);
    check({name, "_Cb"}, post_img_Cb, 32'd0);
    check({name, "_Cr"}, post_img_Cr, 32'd0);
    check({name, "_sync"}, {post_frame_vsync, post_frame_href, post_frame_clken, post_chroma_sel}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    idle(3);

    // Frame A: 601 full, 4:4:4; mid-frame mode change must be ignored.
    vsync_pulse(2'd0, 1'b0);
    pix(8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 1'b0);
    pix(8'd0,   8'd0,   8'd255, 8'd29,  8'd255, 8'd107, 1'b0);
    gap();
    pix(8'd0,   8'd255, 8'd0,   8'd149, 8'd43,  8'd21,  1'b0);
    idle(3);
    cfg_mode = 2'd2;
    pix(8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 1'b0);
    pix(8'd0,   8'd255, 8'd0,   8'd149, 8'd43,  8'd21,  1'b0);
    idle(3);

    // Frame B: 709 full.
    vsync_pulse(2'd2, 1'b0);
    pix(8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 1'b0);
    pix(8'd0,   8'd255, 8'd0,   8'd182, 8'd29,  8'd12,  1'b0);
    idle(3);

    // Frame C: 601 studio range.
    vsync_pulse(2'd1, 1'b0);
    pix(8'd255, 8'd255, 8'd255, 8'd235, 8'd128, 8'd128, 1'b0);
    pix(8'd0,   8'd0,   8'd0,   8'd16,  8'd128, 8'd128, 1'b0);
    idle(3);

    // Frame: reserved code 3 behaves as 601 full.
    vsync_pulse(2'd3, 1'b0);
    pix(8'd0, 8'd255, 8'd0, 8'd149, 8'd43, 8'd21, 1'b0);
    idle(3);

    // Frame D: 601 full, 4:2:2, odd-length line with clken gaps, then a new line.
    vsync_pulse(2'd0, 1'b1);
    pix(8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd0, 1'b0);
    gap();
    pix(8'd0,   8'd0,   8'd255, 8'd29,  8'd118, 8'd0, 1'b1);
    gap();
    gap();
    pix(8'd0,   8'd255, 8'd0,   8'd149, 8'd149, 8'd0, 1'b0);
    idle(3);
    pix(8'd0,   8'd255, 8'd0,   8'd149, 8'd43,  8'd0, 1'b0);
    pix(8'd0,   8'd0,   8'd255, 8'd29,  8'd64,  8'd0, 1'b1);
    idle(6);

    // Frame E: 709 4:2:2, reset asserted mid-line.
    vsync_pulse(2'd2, 1'b1);
    pix(8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd0, 1'b0);
    pix(8'd0,   8'd255, 8'd0,   8'd182, 8'd70,  8'd0, 1'b1);
    pix(8'd255, 8'd255, 8'd255, 8'd255, 8'd79,  8'd0, 1'b0);
    pix(8'd0,   8'd255, 8'd0,   8'd182, 8'd70,  8'd0, 1'b1);
    pix(8'd255, 8'd255, 8'd255, 8'd255, 8'd79,  8'd0, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    per_frame_href = 1'b0;
    per_frame_clken = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb_q.delete();
    vs_q.delete();
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    idle(3);
    // cfg inputs still say 709/4:2:2, but no vsync edge yet: 601 full 4:4:4.
    pix(8'd0, 8'd255, 8'd0, 8'd149, 8'd43, 8'd21, 1'b0);
    idle(2);

    for (int i = 0; i < 20 && (sb_q.size() != 0 || vs_q.size() != 0); i++) @(posedge clk);
    check("pixel_queue_drained", sb_q.size(), 32'd0);
    check("vsync_queue_drained", vs_q.size(), 32'd0);
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
